// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first.
// One result bit is produced per clock. The borrow between bits is kept in a register.
// A start/busy/done handshake controls it.
// diff/borrow change only when a subtraction completes or on reset.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_sh_reg, a_sh_next;
    logic [WIDTH-1:0]  b_sh_reg, b_sh_next;
    logic [WIDTH-1:0]  res_sh_reg, res_sh_next;
    logic              br_reg, br_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [WIDTH-1:0]  diff_reg, diff_next;
    logic              borrow_reg, borrow_next;

    // Full-subtractor slice on the current LSBs and the borrow that carries to the next bit.
    logic              ai, bi, d_bit, br_calc;
    logic [WIDTH-1:0]  res_shifted;

    assign ai      = a_sh_reg[0];
    assign bi      = b_sh_reg[0];
    assign d_bit   = ai ^ bi ^ br_reg;
    assign br_calc = (~ai & bi) | (~(ai ^ bi) & br_reg);

    // Result register shifted right.
    // The new bit enters at the MSB, so after WIDTH bits the LSB lands at bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_res_shift
            assign res_shifted[gi] = res_sh_reg[gi+1];
        end
    endgenerate
    assign res_shifted[WIDTH-1] = d_bit;

    // Next-state and datapath logic.
    // A start seen in IDLE or DONE loads fresh operands.
    // RUN consumes one bit per cycle.
    always_comb begin
        state_next  = state_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        res_sh_next = res_sh_reg;
        br_next     = br_reg;
        cnt_next    = cnt_reg;
        diff_next   = diff_reg;
        borrow_next = borrow_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_next  = a;
                    b_sh_next  = b;
                    br_next    = 1'b0;
                    cnt_next   = '0;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                a_sh_next   = a_sh_reg >> 1;
                b_sh_next   = b_sh_reg >> 1;
                res_sh_next = res_shifted;
                br_next     = br_calc;
                cnt_next    = cnt_reg + CW'(1);
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    diff_next   = res_shifted;
                    borrow_next = br_calc;
                    cnt_next    = '0;
                    state_next  = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    // Reset discards any partial result and clears the visible outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            br_reg     <= 1'b0;
            cnt_reg    <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            res_sh_reg <= res_sh_next;
            br_reg     <= br_next;
            cnt_reg    <= cnt_next;
            diff_reg   <= diff_next;
            borrow_reg <= borrow_next;
        end
    end

    assign busy   = (state_reg == RUN);
    assign done   = (state_reg == DONE);
    assign diff   = diff_reg;
    assign borrow = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH=8).
// Inputs are driven 1 ns after each rising edge.
// Outputs are sampled at the same point.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    int vectors = 0;
    int miscompares = 0;
    int done_count;

    // Diff/borrow the DUT should currently be holding.
    logic [WIDTH-1:0] hold_diff = '0;
    logic             hold_borrow = 1'b0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Start one subtraction, then walk the RUN phase.
    // If ign_at >= 0, a stray start with zero operands is pulsed in that RUN cycle.
    // Returns with the DUT in its DONE cycle.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] exp_d, input logic exp_b, input int ign_at);
        start = 1'b1; a = av; b = bv;
        tick();                          // accepting edge E0
        done_count = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == ign_at) begin
                start = 1'b1; a = 8'h00; b = 8'h00;
            end else begin
                start = 1'b0; a = ~av; b = ~bv;   // operands may change freely
            end
            check($sformatf("busy_run%0d", i), {31'd0, busy}, 32'd1);
            check($sformatf("diff_hold%0d", i), {24'd0, diff}, {24'd0, hold_diff});
            if (done) done_count++;
            tick();
        end
        start = 1'b0;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_done", {31'd0, busy}, 32'd0);
        check("diff", {24'd0, diff}, {24'd0, exp_d});
        check("borrow", {31'd0, borrow}, {31'd0, exp_b});
        check("no_early_done", done_count, 0);
        hold_diff = exp_d;
        hold_borrow = exp_b;
        $display("op a=0x%02h b=0x%02h -> diff=0x%02h borrow=%0d", av, bv, diff, borrow);
    endtask

    // Leave the DONE cycle with start low and confirm the DUT returns to IDLE.
    task automatic to_idle();
        start = 1'b0;
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_diff_hold", {24'd0, diff}, {24'd0, hold_diff});
        check("idle_borrow_hold", {31'd0, borrow}, {31'd0, hold_borrow});
    endtask

    initial begin
        // Reset, held across an asserted start: rst must win.
        rst = 1'b1; start = 1'b1; a = 8'h55; b = 8'h11;
        tick();
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);
        $display("reset: busy=%0d done=%0d diff=0x%02h borrow=%0d", busy, done, diff, borrow);
        tick();
        check("idle_after_rst", {31'd0, busy}, 32'd0);

        run_op(8'h3C, 8'h15, 8'h27, 1'b0, -1); to_idle();
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, -1); to_idle();
        run_op(8'h80, 8'hFF, 8'h81, 1'b1, -1); to_idle();
        run_op(8'hAA, 8'hAA, 8'h00, 1'b0, -1); to_idle();
        run_op(8'hFF, 8'h00, 8'hFF, 1'b0, -1); to_idle();

        // A start pulsed in RUN cycle 3 is ignored.
        // A back-to-back start is then raised during the DONE cycle.
        run_op(8'h10, 8'h01, 8'h0F, 1'b0, 2);
        run_op(8'h05, 8'h07, 8'hFE, 1'b1, -1);
        to_idle();

        // Reset asserted in RUN cycle 4.
        start = 1'b1; a = 8'h3C; b = 8'h15;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_diff", {24'd0, diff}, 32'd0);
        check("midrst_borrow", {31'd0, borrow}, 32'd0);
        $display("mid-run reset: busy=%0d done=%0d diff=0x%02h borrow=%0d", busy, done, diff, borrow);
        hold_diff = 8'h00; hold_borrow = 1'b0;
        done_count = 0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            if (done) done_count++;
            tick();
        end
        check("midrst_no_done", done_count, 0);

        // A fresh start after the reset.
        run_op(8'h3C, 8'h15, 8'h27, 1'b0, -1); to_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
